// File: rtl/nano_rv32i_pkg.sv
// Shared encodings for the nano_rv32i memory arbiter: FSM states, owner ids,
// latency counter width.
package nano_rv32i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Wide enough for MEM_LATENCY - 1 with MEM_LATENCY up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/nano_arb_pick.sv
// Combinational owner selection between the fetch and data ports.
module nano_arb_pick
  import nano_rv32i_pkg::*;
#(
  parameter bit PRIO_D = 1'b1
) (
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_owner
);

  // Fixed data priority, or alternate away from the last winner on conflict.
  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWN_I;
    if (i_req && d_req) begin
      grant_owner = PRIO_D ? OWN_D : ~last_grant;
    end else if (d_req) begin
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/nano_mem_arbiter.sv
// Two-port arbiter in front of a single-port, fixed-latency unified memory.
// One access at a time: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
module nano_mem_arbiter
  import nano_rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter bit          PRIO_D      = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_rd_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_data_o,
  output logic              i_ack_o,
  input  logic              d_rd_i,
  input  logic              d_wr_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic               owner_q, owner_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               mem_req_q, mem_req_d;
  logic               i_ack_q, i_ack_d;
  logic               d_ack_q, d_ack_d;
  logic [DATA_W-1:0]  i_data_q, i_data_d;
  logic [DATA_W-1:0]  d_data_q, d_data_d;

  logic grant_valid;
  logic grant_owner;

  nano_arb_pick #(
    .PRIO_D (PRIO_D)
  ) u_pick (
    .i_req       (i_rd_i),
    .d_req       (d_rd_i | d_wr_i),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Next-state logic; every output is produced one edge ahead so it leaves a flop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_req_d    = 1'b0;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_data_d     = i_data_q;
    d_data_d     = d_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_owner;
          last_grant_d = grant_owner;
          if (grant_owner == OWN_D) begin
            // A simultaneous read and write is served as a write.
            we_d    = d_wr_i;
            addr_d  = d_addr_i;
            wdata_d = d_data_i;
          end else begin
            we_d    = 1'b0;
            addr_d  = i_addr_i;
            wdata_d = '0;
          end
          mem_req_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY - 32'd1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q == OWN_D) begin
              d_data_d = mem_rdata_i;
            end else begin
              i_data_d = mem_rdata_i;
            end
          end
          i_ack_d = (owner_q == OWN_I);
          d_ack_d = (owner_q == OWN_D);
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and latched access registers; reset aborts any access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= OWN_I;
      owner_q      <= OWN_I;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_req_q    <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_data_q     <= '0;
      d_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_req_q    <= mem_req_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_data_q     <= i_data_d;
      d_data_q     <= d_data_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign i_ack_o     = i_ack_q;
  assign d_ack_o     = d_ack_q;
  assign i_data_o    = i_data_q;
  assign d_data_o    = d_data_q;

endmodule

// File: doc/nano_mem_arbiter.md
# nano_mem_arbiter

Shares one single-port, fixed-latency unified memory between the nano_rv32i instruction-fetch port and data port. Each requester holds a level request until a one-cycle acknowledge. Internally the block runs a 4-state FSM with a latency counter and fixed-priority or round-robin arbitration. It sits between the core and the memory; the core stalls on a missing ack.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from mem_req_o to valid mem_rdata_i; legal 1..15
- PRIO_D, 1, 1 = data port has fixed priority; 0 = round-robin

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- i_rd_i  in  1  fetch request, level, held until i_ack_o
- i_addr_i  in  ADDR_W  fetch address, stable while i_rd_i
- i_data_o  out  DATA_W  fetched word, valid with i_ack_o, held until next i_ack_o
- i_ack_o  out  1  one-cycle fetch-complete pulse
- d_rd_i  in  1  load request, level
- d_wr_i  in  1  store request, level
- d_addr_i  in  ADDR_W  data address
- d_data_i  in  DATA_W  store data
- d_data_o  out  DATA_W  load data, valid with d_ack_o on loads; unchanged on stores
- d_ack_o  out  1  one-cycle data-complete pulse
- mem_req_o  out  1  one-cycle memory strobe
- mem_we_o  out  1  write enable, qualified by mem_req_o
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  read data, valid MEM_LATENCY cycles after mem_req_o

## Operation
- States:
  - IDLE: sample requests. If none, stay. Otherwise pick owner; latch addr, we, wdata; go to ISSUE.
  - ISSUE: mem_req_o=1 for exactly one cycle; load cnt=MEM_LATENCY-1; go to WAIT.
  - WAIT: cnt decrements each cycle. When cnt==0, capture mem_rdata_i into the owner's data register (reads only) and go to ACK.
  - ACK: pulse the owner's ack; go to IDLE.
- Arbitration in IDLE, when both ports request:
  - PRIO_D=1: data wins.
  - PRIO_D=0: the port not granted last wins. last_grant updates on every grant.
- d_rd_i and d_wr_i both high: treated as a write; the read is ignored.
- Requests are level: an unacked requester is re-evaluated every IDLE. Starvation of fetch under PRIO_D=1 is accepted, because the core issues one data access per instruction.
- mem_addr_o, mem_we_o and mem_wdata_o are driven from the latched registers and stay stable from ISSUE through ACK.
- Requester inputs are ignored outside IDLE. Changing a request before its ack is illegal.

## Timing
- Request first high in IDLE cycle T:
  - ISSUE at T+1
  - rdata sampled at T+1+MEM_LATENCY
  - ack at T+2+MEM_LATENCY
  - IDLE again at T+3+MEM_LATENCY
- Throughput: one access per MEM_LATENCY+3 cycles. No overlap of accesses.
- Requester reacts to the ack at the closing edge of the ACK cycle. The next IDLE therefore sees the requester's updated request.
- Reset values: state=IDLE, cnt=0, last_grant=I, all acks 0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, i_data_o=0, d_data_o=0.
- Reset mid-operation: the access is aborted, no ack is issued, and rdata still in flight is ignored. mem_req_o=0 from the cycle after the reset edge.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package nano_rv32i_pkg holds:
  - state encoding localparams ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK
  - owner encoding OWN_I=0, OWN_D=1
- One sub-module, nano_arb_pick (combinational):
  - inputs: i_req, d_req, last_grant, PRIO_D
  - outputs: grant_valid, grant_owner
- The FSM, counter and latches live in the top module.

## Test plan
- Fetch only, MEM_LATENCY=1: i_rd_i=1, i_addr_i=0x4 at T, mem returns 0x0000d663. Expected: mem_req_o at T+1 with addr 0x4, we=0; i_ack_o at T+3; i_data_o=0x0000d663.
- Store, MEM_LATENCY=2: d_wr_i=1, addr 0x10, data 0xDEADBEEF. Expected: mem_req_o=1, mem_we_o=1, mem_wdata_o=0xDEADBEEF at T+1; d_ack_o at T+4; d_data_o unchanged.
- Conflict, PRIO_D=1: i_rd_i and d_rd_i high together. Expected: data served first (d_ack_o at T+3); fetch issued at T+5 (ISSUE), i_ack_o at T+7.
- Conflict, PRIO_D=0, both held through 4 accesses: grants alternate D, I, D, I, since last_grant=I at reset.
- d_rd_i=d_wr_i=1: expected mem_we_o=1 and d_ack_o with d_data_o unchanged.
- rst_i asserted in WAIT with MEM_LATENCY=3: no ack ever issued; state IDLE and mem_req_o=0 next cycle. A new fetch afterwards completes normally.
